// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl
//
// Purpose:
//   Runs one tile pass of a weight-stationary systolic array. It loads the
//   weight tile, then streams the buffered A tile into the array with a
//   diagonal skew. It can feed the previous pass's partial sums into the
//   array's B inputs so that K-dimension tiles accumulate. The deskewed C rows
//   coming back from the array are captured into an internal partial-sum
//   buffer.
//
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   start, acc    begin a pass (IDLE only); acc selects partial-sum feed into B
//   wt_in         weight tile, row-major, element (i,j) in slice i*N_SIZE+j
//   a_wr_*        write port of the A-row buffer (ignored while busy)
//   ps_rd_*       combinational read port of the partial-sum buffer
//   busy, done    pass status; done is a one-cycle pulse at the end of a pass
//   wt_en, valid_in, wt_flat, mat_a, mat_b   drive the array
//   mat_c         deskewed result rows from the array
module systolic_tile_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 2,
  parameter int M_ROWS    = 4,
  parameter int CAP_DLY   = N_SIZE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                acc,
  input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  wt_in,
  input  logic                                a_wr_en,
  input  logic [$clog2(M_ROWS)-1:0]           a_wr_row,
  input  logic [N_SIZE*DATAWIDTH-1:0]         a_wr_data,
  input  logic [$clog2(M_ROWS)-1:0]           ps_rd_row,
  output logic [N_SIZE*4*DATAWIDTH-1:0]       ps_rd_data,
  output logic                                busy,
  output logic                                done,
  output logic                                wt_en,
  output logic                                valid_in,
  output logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  wt_flat,
  output logic [N_SIZE*DATAWIDTH-1:0]         mat_a,
  output logic [N_SIZE*4*DATAWIDTH-1:0]       mat_b,
  input  logic [N_SIZE*4*DATAWIDTH-1:0]       mat_c
);

  localparam int PW          = 4 * DATAWIDTH;
  localparam int ROWW        = $clog2(M_ROWS);
  localparam int LAST_STREAM = M_ROWS + N_SIZE - 2;
  localparam int LAST_CAP    = M_ROWS - 1 + CAP_DLY;
  localparam int K_MAX       = (LAST_CAP > LAST_STREAM) ? LAST_CAP : LAST_STREAM;
  localparam int KW          = $clog2(K_MAX + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } stateT;

  stateT                              r_state;
  logic [KW-1:0]                      r_k;
  logic                               r_acc;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_wtEn;
  logic                               r_valid;
  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0] r_wtFlat;
  logic [N_SIZE*DATAWIDTH-1:0]        r_matA;
  logic [N_SIZE*PW-1:0]               r_matB;

  logic [N_SIZE*DATAWIDTH-1:0]        r_aBuf  [M_ROWS];
  logic [N_SIZE*PW-1:0]               r_psBuf [M_ROWS];

  logic [KW-1:0]                      w_kNext;
  logic [N_SIZE*DATAWIDTH-1:0]        w_aNext;
  logic [N_SIZE*PW-1:0]               w_bNext;
  logic                               w_capEn;
  logic [ROWW-1:0]                    w_capRow;

  assign busy       = r_busy;
  assign done       = r_done;
  assign wt_en      = r_wtEn;
  assign valid_in   = r_valid;
  assign wt_flat    = r_wtFlat;
  assign mat_a      = r_matA;
  assign mat_b      = r_matB;
  assign ps_rd_data = r_psBuf[ps_rd_row];

  // Array inputs are registered, so the values for stream cycle k are built
  // one cycle early from the index of the next stream cycle. Lane i lags
  // lane 0 by i cycles (diagonal skew); lanes outside the tile read as zero.
  always_comb begin
    w_kNext = (r_state == ST_GAP) ? '0 : r_k + KW'(1);
    w_aNext = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      if (int'(w_kNext) >= i && int'(w_kNext) - i < M_ROWS) begin
        w_aNext[i*DATAWIDTH +: DATAWIDTH] =
          r_aBuf[ROWW'(int'(w_kNext) - i)][i*DATAWIDTH +: DATAWIDTH];
      end
    end
    w_bNext = '0;
    if (r_acc && int'(w_kNext) < M_ROWS) begin
      w_bNext = r_psBuf[ROWW'(w_kNext)];
    end
  end

  // Output row r shows up on mat_c CAP_DLY cycles after stream cycle r, so
  // the capture row trails the stream counter. The counter keeps running in
  // DRAIN, which lets the tail rows be captured after streaming stops.
  always_comb begin
    w_capEn  = 1'b0;
    w_capRow = '0;
    if ((r_state == ST_STREAM || r_state == ST_DRAIN) &&
        int'(r_k) >= CAP_DLY && int'(r_k) - CAP_DLY < M_ROWS) begin
      w_capEn  = 1'b1;
      w_capRow = ROWW'(int'(r_k) - CAP_DLY);
    end
  end

  // A-row and partial-sum buffers. A rows are only writable in IDLE so the
  // tile cannot change under a running pass. ps[r] is read for B in cycle r
  // and overwritten no earlier than cycle r+1, so one buffer is enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < M_ROWS; r++) begin
        r_aBuf[r]  <= '0;
        r_psBuf[r] <= '0;
      end
    end else begin
      if (a_wr_en && r_state == ST_IDLE && int'(a_wr_row) < M_ROWS) begin
        r_aBuf[a_wr_row] <= a_wr_data;
      end
      if (w_capEn) begin
        r_psBuf[w_capRow] <= mat_c;
      end
    end
  end

  // Pass sequencer: IDLE -> LOAD -> GAP -> STREAM -> DRAIN -> DONE -> IDLE.
  // Every array-facing output is registered here. wt_flat doubles as the
  // weight latch and holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_acc    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wtEn   <= 1'b0;
      r_valid  <= 1'b0;
      r_wtFlat <= '0;
      r_matA   <= '0;
      r_matB   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc    <= acc;
            r_wtFlat <= wt_in;
            r_wtEn   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_wtEn  <= 1'b0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_k     <= '0;
          r_valid <= 1'b1;
          r_matA  <= w_aNext;
          r_matB  <= w_bNext;
          r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          r_k <= r_k + KW'(1);
          if (r_k == KW'(LAST_STREAM)) begin
            r_valid <= 1'b0;
            r_matA  <= '0;
            r_matB  <= '0;
            if (r_k == KW'(LAST_CAP)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_matA <= w_aNext;
            r_matB <= w_bNext;
          end
        end
        ST_DRAIN: begin
          r_k <= r_k + KW'(1);
          if (r_k == KW'(LAST_CAP)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
